// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer: FSM states, ROM entry layout,
// pitch codes, note durations in ticks and the built-in song table.
package note_pkg;

   localparam int unsigned PITCH_W = 6;
   localparam int unsigned DUR_W   = 9;
   localparam int unsigned ENTRY_W = PITCH_W + DUR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [PITCH_W-1:0] pitch;
      logic [DUR_W-1:0]   dur;
   } rom_entry_t;

   // Pitch codes, two octaves of semitones; 0 is a rest.
   localparam logic [PITCH_W-1:0] REST = 6'd0;
   localparam logic [PITCH_W-1:0] C4   = 6'd1;
   localparam logic [PITCH_W-1:0] CS4  = 6'd2;
   localparam logic [PITCH_W-1:0] D4   = 6'd3;
   localparam logic [PITCH_W-1:0] DS4  = 6'd4;
   localparam logic [PITCH_W-1:0] E4   = 6'd5;
   localparam logic [PITCH_W-1:0] F4   = 6'd6;
   localparam logic [PITCH_W-1:0] FS4  = 6'd7;
   localparam logic [PITCH_W-1:0] G4   = 6'd8;
   localparam logic [PITCH_W-1:0] GS4  = 6'd9;
   localparam logic [PITCH_W-1:0] A4   = 6'd10;
   localparam logic [PITCH_W-1:0] AS4  = 6'd11;
   localparam logic [PITCH_W-1:0] B4   = 6'd12;
   localparam logic [PITCH_W-1:0] C5   = 6'd13;
   localparam logic [PITCH_W-1:0] CS5  = 6'd14;
   localparam logic [PITCH_W-1:0] D5   = 6'd15;
   localparam logic [PITCH_W-1:0] DS5  = 6'd16;
   localparam logic [PITCH_W-1:0] E5   = 6'd17;
   localparam logic [PITCH_W-1:0] F5   = 6'd18;
   localparam logic [PITCH_W-1:0] FS5  = 6'd19;
   localparam logic [PITCH_W-1:0] G5   = 6'd20;
   localparam logic [PITCH_W-1:0] GS5  = 6'd21;
   localparam logic [PITCH_W-1:0] A5   = 6'd22;
   localparam logic [PITCH_W-1:0] AS5  = 6'd23;
   localparam logic [PITCH_W-1:0] B5   = 6'd24;

   // Durations in ticks; 100 ticks make one quarter note.
   localparam logic [DUR_W-1:0] WHOLE     = 9'd400;
   localparam logic [DUR_W-1:0] HALF      = 9'd200;
   localparam logic [DUR_W-1:0] QUARTER   = 9'd100;
   localparam logic [DUR_W-1:0] EIGHTH    = 9'd50;
   localparam logic [DUR_W-1:0] SIXTEENTH = 9'd25;

   localparam rom_entry_t END_MARK = '0;

   // Song contents; any address past the listed notes reads as the end marker.
   function automatic rom_entry_t song_entry(input int unsigned addr);
      rom_entry_t e;
      e = END_MARK;
      case (addr)
         0:       e = '{pitch: C4,   dur: QUARTER};
         1:       e = '{pitch: REST, dur: EIGHTH};
         2:       e = '{pitch: E4,   dur: 9'd0};
         default: e = END_MARK;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM: registered output, one-cycle latency, contents from note_pkg.
module song_rom
   import note_pkg::*;
#(
   parameter int unsigned SONG_LEN = 32,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               rd_en_i,
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [ENTRY_W-1:0] data_o
);

   rom_entry_t data_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         data_q <= END_MARK;
      end else if (rd_en_i) begin
         data_q <= (32'(addr_i) < SONG_LEN) ? song_entry(32'(addr_i)) : END_MARK;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks song_rom, holding each pitch for its duration in upstream ticks.
// Optional articulation gap (NOTE_GAP_EN) mutes the last GAP_TICKS ticks of every note.
module note_sequencer
   import note_pkg::*;
#(
   parameter int unsigned SONG_LEN  = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned GAP_TICKS = 10
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               tick,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   output logic [PITCH_W-1:0] pitch,
   output logic               sounding,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  note_idx
);

   if (SONG_LEN > (32'd1 << ADDR_W) || GAP_TICKS >= (32'd1 << DUR_W)) begin : g_bad_params
      $error("note_sequencer: SONG_LEN or GAP_TICKS out of range");
   end

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [PITCH_W-1:0] pitch_q, pitch_d;
   logic [DUR_W-1:0]   rem_q, rem_d;
   logic               snd_d;
   logic               last_idx;
   logic [ENTRY_W-1:0] rom_data;
   rom_entry_t         rom_q;

   song_rom #(
      .SONG_LEN (SONG_LEN),
      .ADDR_W   (ADDR_W)
   ) u_song_rom (
      .clk     (clk),
      .clr     (clr),
      .rd_en_i (state_q == ST_FETCH),
      .addr_i  (idx_q),
      .data_o  (rom_data)
   );

   assign rom_q    = rom_data;
   assign last_idx = (idx_q == ADDR_W'(SONG_LEN - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pitch_d = pitch_q;
      rem_d   = rem_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pitch_d = rom_q.pitch;
            rem_d   = rom_q.dur;
            if (rom_q.dur != '0) begin
               state_d = ST_PLAY;
            end else if (loop_en) begin
               idx_d   = '0;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_PLAY: begin
            // The tick that consumes the last remaining unit ends the note.
            if (tick && rem_q != '0) begin
               rem_d = rem_q - DUR_W'(1);
               if (rem_q == DUR_W'(1)) begin
                  if (!last_idx) begin
                     idx_d   = idx_q + ADDR_W'(1);
                     state_d = ST_FETCH;
                  end else if (loop_en) begin
                     idx_d   = '0;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (stop) state_d = ST_IDLE;

      if (state_d == ST_IDLE) begin
         idx_d   = '0;
         pitch_d = '0;
         rem_d   = '0;
      end else if (state_d == ST_DONE) begin
         pitch_d = '0;
      end
   end

`ifdef NOTE_GAP_EN
   localparam logic [DUR_W-1:0] GAP_LIM = DUR_W'(GAP_TICKS);

   always_comb begin
      snd_d = (state_d == ST_PLAY) && (pitch_d != '0);
      if (rem_d <= GAP_LIM) snd_d = 1'b0;
   end
`else
   always_comb begin
      snd_d = (state_d == ST_PLAY) && (pitch_d != '0);
   end
`endif

   // Status outputs are registered from next-state so they line up with state_q.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         pitch_q  <= '0;
         rem_q    <= '0;
         sounding <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pitch_q  <= pitch_d;
         rem_q    <= rem_d;
         sounding <= snd_d;
         busy     <= (state_d != ST_IDLE);
         done     <= (state_d == ST_DONE);
      end
   end

   assign pitch    = pitch_q;
   assign note_idx = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (32-entry and 2-entry songs) against a note-level model.
module tb_note_sequencer;

   localparam int unsigned GAP_TICKS = 10;
`ifdef NOTE_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif
   localparam int P_C4 = 1;
   localparam int P_E4 = 5;

   localparam int PH_OFF   = 0;
   localparam int PH_READ  = 1;
   localparam int PH_LATCH = 2;
   localparam int PH_NOTE  = 3;
   localparam int PH_END   = 4;

   typedef struct {
      int ph;
      int idx;
      int pitch;
      int left;
   } mdl_t;

   localparam mdl_t MDL_RST = '{0, 0, 0, 0};

   logic       clk = 1'b0;
   logic       clr, tick, start, stop, loop_en;
   logic [5:0] pitch_a, pitch_b;
   logic [4:0] idx_a;
   logic [0:0] idx_b;
   logic       snd_a, busy_a, done_a, snd_b, busy_b, done_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   mdl_t ma, mb;

   note_sequencer #(.SONG_LEN(32), .ADDR_W(5), .GAP_TICKS(GAP_TICKS)) u_dut_a (
      .clk(clk), .clr(clr), .tick(tick), .start(start), .stop(stop), .loop_en(loop_en),
      .pitch(pitch_a), .sounding(snd_a), .busy(busy_a), .done(done_a), .note_idx(idx_a)
   );

   note_sequencer #(.SONG_LEN(2), .ADDR_W(1), .GAP_TICKS(GAP_TICKS)) u_dut_b (
      .clk(clk), .clr(clr), .tick(tick), .start(start), .stop(stop), .loop_en(loop_en),
      .pitch(pitch_b), .sounding(snd_b), .busy(busy_b), .done(done_b), .note_idx(idx_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // The song as written down: C4 quarter, eighth rest, end marker.
   function automatic int ref_pitch(input int i);
      if (i == 0) return P_C4;
      if (i == 2) return P_E4;
      return 0;
   endfunction

   function automatic int ref_dur(input int i);
      if (i == 0) return 100;
      if (i == 1) return 50;
      return 0;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int len, input bit st, input bit sp,
                                     input bit lp, input bit tk);
      mdl_t n;
      n = m;
      if (sp) return MDL_RST;
      case (m.ph)
         PH_OFF:   if (st) n.ph = PH_READ;
         PH_READ:  n.ph = PH_LATCH;
         PH_LATCH: begin
            n.pitch = ref_pitch(m.idx);
            n.left  = ref_dur(m.idx);
            if (n.left > 0) n.ph = PH_NOTE;
            else if (lp) begin n.ph = PH_READ; n.idx = 0; end
            else begin n.ph = PH_END; n.pitch = 0; end
         end
         PH_NOTE: if (tk) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
               if (m.idx + 1 < len) begin n.idx = m.idx + 1; n.ph = PH_READ; end
               else if (lp) begin n.idx = 0; n.ph = PH_READ; end
               else begin n.ph = PH_END; n.pitch = 0; end
            end
         end
         default: n = MDL_RST;
      endcase
      return n;
   endfunction

   function automatic logic m_snd(input mdl_t m);
      return (m.ph == PH_NOTE) && (m.pitch != 0) && (!GAP_ON || m.left > int'(GAP_TICKS));
   endfunction

   // One clock: advance the models on the edge, compare both instances half a cycle later.
   task automatic step();
      @(posedge clk);
      if (clr) begin
         ma = MDL_RST;
         mb = MDL_RST;
      end else begin
         ma = mdl_step(ma, 32, start, stop, loop_en, tick);
         mb = mdl_step(mb, 2, start, stop, loop_en, tick);
      end
      @(negedge clk);
      check_eq("outs_a", {18'd0, pitch_a, idx_a, snd_a, busy_a, done_a},
               {18'd0, 6'(ma.pitch), 5'(ma.idx), m_snd(ma), ma.ph != PH_OFF, ma.ph == PH_END});
      check_eq("outs_b", {22'd0, pitch_b, idx_b, snd_b, busy_b, done_b},
               {22'd0, 6'(mb.pitch), 1'(mb.idx), m_snd(mb), mb.ph != PH_OFF, mb.ph == PH_END});
   endtask

   task automatic wait_play(input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 8 && !ok; c++) begin
         if (busy_a && pitch_a == 6'(P_C4) && idx_a == 5'd0) ok = 1'b1;
         else step();
      end
      check_eq(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      int snd_cnt, rest_cnt, done_cnt, max_idx, b_done_cnt, b_done_idx, b_max_idx, dens;
      bit seen2, wrapped, resound;

      clr = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      ma = MDL_RST; mb = MDL_RST;
      #1;
      check_eq("reset_a", {18'd0, pitch_a, idx_a, snd_a, busy_a, done_a}, 32'd0);
      check_eq("reset_b", {22'd0, pitch_b, idx_b, snd_b, busy_b, done_b}, 32'd0);
      repeat (3) step();
      clr = 1'b0;
      step();

      // Plain playback: C4 quarter, eighth rest, single done pulse.
      tick = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      snd_cnt = 0; rest_cnt = 0; done_cnt = 0; max_idx = 0;
      b_done_cnt = 0; b_done_idx = -1; b_max_idx = 0;
      for (int c = 0; c < 400 && busy_a; c++) begin
         step();
         if (snd_a && pitch_a == 6'(P_C4)) snd_cnt++;
         if (busy_a && pitch_a == 6'd0 && idx_a == 5'd1) rest_cnt++;
         if (done_a) done_cnt++;
         if (int'(idx_a) > max_idx) max_idx = int'(idx_a);
         if (done_b) begin b_done_cnt++; b_done_idx = int'(idx_b); end
         if (int'(idx_b) > b_max_idx) b_max_idx = int'(idx_b);
      end
      check_eq("c4_sound_ticks", 32'(snd_cnt), GAP_ON ? 32'd90 : 32'd100);
      check_eq("rest_ticks", 32'(rest_cnt), 32'd50);
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("busy_after_song", 32'(busy_a), 32'd0);
      check_eq("max_idx_a", 32'(max_idx), 32'd2);
      check_eq("wrap_done_pulses_b", 32'(b_done_cnt), 32'd1);
      check_eq("wrap_done_idx_b", 32'(b_done_idx), 32'd1);
      check_eq("wrap_max_idx_b", 32'(b_max_idx), 32'd1);

      // Looping: index returns to 0 after the end marker, no done, C4 again.
      loop_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      seen2 = 1'b0; wrapped = 1'b0; resound = 1'b0; done_cnt = 0;
      for (int c = 0; c < 600 && !resound; c++) begin
         step();
         if (done_a) done_cnt++;
         if (idx_a == 5'd2) seen2 = 1'b1;
         if (seen2 && idx_a == 5'd0) wrapped = 1'b1;
         if (wrapped && snd_a && pitch_a == 6'(P_C4)) resound = 1'b1;
      end
      check_eq("loop_wrapped", 32'(wrapped), 32'd1);
      check_eq("loop_no_done", 32'(done_cnt), 32'd0);
      check_eq("loop_resound", 32'(resound), 32'd1);
      stop = 1'b1;
      step();
      stop = 1'b0; loop_en = 1'b0;
      check_eq("loop_stopped", 32'(busy_a), 32'd0);

      // Stop on the 40th tick of C4.
      start = 1'b1;
      step();
      start = 1'b0;
      wait_play("stop_reach_play");
      repeat (39) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_eq("stop_state", {28'd0, busy_a, snd_a, done_a, |pitch_a}, 32'd0);
      step();
      check_eq("stop_no_done", 32'(done_a), 32'd0);

      // Asynchronous clear mid-note with a coincident tick, then replay from entry 0.
      start = 1'b1;
      step();
      start = 1'b0;
      wait_play("clr_reach_play");
      repeat (20) step();
      tick = 1'b1; clr = 1'b1;
      #1;
      check_eq("clr_async_a", {18'd0, pitch_a, idx_a, snd_a, busy_a, done_a}, 32'd0);
      check_eq("clr_async_b", {22'd0, pitch_b, idx_b, snd_b, busy_b, done_b}, 32'd0);
      step();
      clr = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      wait_play("clr_replay");
      stop = 1'b1;
      step();
      stop = 1'b0;

      // Randomized control traffic against the model.
      dens = 100;
      for (int c = 0; c < 15000; c++) begin
         if (c % 1000 == 0) dens = int'($urandom_range(20, 100));
         tick  = ($urandom_range(0, 99) < dens);
         start = ($urandom_range(0, 19) == 0);
         stop  = ($urandom_range(0, 599) == 0);
         clr   = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 299) == 0) loop_en = ~loop_en;
         step();
      end

      clr = 1'b0; start = 1'b0; stop = 1'b1;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter SONG_LEN, default 32: number of ROM entries, at most 2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 5: note index width.
REQ-003 SHALL have parameter GAP_TICKS, default 10: articulation gap length in ticks; used only when NOTE_GAP_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tick, input, 1 bit: one-cycle duration pulse from the upstream pulse generator; 100 ticks = one quarter note.
REQ-007 SHALL have port start, input, 1 bit: begin playback at entry 0.
REQ-008 SHALL have port stop, input, 1 bit: abort playback.
REQ-009 SHALL have port loop_en, input, 1 bit: wrap to entry 0 at end of song instead of finishing.
REQ-010 SHALL have port pitch, output, 6 bits: pitch code for the downstream tone generator; 0 = rest.
REQ-011 SHALL have port sounding, output, 1 bit: tone generator output enable.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle end-of-song pulse.
REQ-014 SHALL have port note_idx, output, ADDR_W bits: index of the current ROM entry.

Function
REQ-015 SHALL read ROM entries as {pitch[5:0], dur[8:0]}, where dur is in ticks (whole = 400, quarter = 100, eighth = 50, sixteenth = 25); dur = 0 marks end of song.
REQ-016 SHALL implement the states IDLE, FETCH, LOAD, PLAY and DONE.
REQ-017 IDLE: note_idx = 0, pitch = 0, sounding = 0; start = 1 SHALL move to FETCH on the next cycle.
REQ-018 FETCH SHALL last exactly one cycle, during which the ROM registers the entry at note_idx; next state is LOAD.
REQ-019 LOAD SHALL last exactly one cycle and latch pitch and remaining = dur; if dur = 0, next state is DONE (or FETCH at index 0 when loop_en = 1); otherwise next state is PLAY.
REQ-020 PLAY SHALL decrement remaining on each tick; a tick with remaining = 1 SHALL advance note_idx and enter FETCH.
REQ-021 Index wrap: advancing from SONG_LEN-1 SHALL enter DONE when loop_en = 0, or set note_idx = 0 and enter FETCH when loop_en = 1.
REQ-022 DONE SHALL assert done for exactly one cycle, clear pitch, and return to IDLE.
REQ-023 sounding SHALL equal (state == PLAY) && (pitch != 0), except as modified by REQ-032.
REQ-024 tick SHALL be ignored in IDLE, FETCH, LOAD and DONE; the maximum dropped time is 2 cycles per note, which is accepted.
REQ-025 stop = 1 in any state SHALL force IDLE on the next edge with pitch = 0 and sounding = 0; done SHALL NOT pulse.
REQ-026 When stop and start are asserted together, stop SHALL win.
REQ-027 start while busy = 1 SHALL be ignored.
REQ-028 remaining SHALL be 9 bits and SHALL never underflow.

Reset
REQ-029 While clr = 1, asynchronously: state = IDLE; note_idx, pitch and remaining = 0; sounding, busy and done = 0.
REQ-030 clr asserted mid-note SHALL silence the output immediately; the upstream tick generator is cleared by the same clr.

Configuration
REQ-031 The feature macro SHALL be NOTE_GAP_EN.
REQ-032 With NOTE_GAP_EN defined, sounding SHALL drop to 0 in PLAY when remaining <= GAP_TICKS, separating repeated notes; pitch SHALL be unchanged.
REQ-033 Without NOTE_GAP_EN, sounding SHALL stay high for the full duration, GAP_TICKS SHALL be unused, and no compare logic SHALL be present.

Structure
REQ-034 Package note_pkg SHALL hold the state enum, the ROM entry struct, the pitch code constants (REST = 0, C4..B5) and the duration constants (WHOLE, HALF, QUARTER, EIGHTH, SIXTEENTH).
REQ-035 Sub-module song_rom SHALL be a synchronous-read ROM (SONG_LEN x 15 bits, contents in note_pkg), registered output, one-cycle latency.

Verification
REQ-036 ROM {C4,100},{REST,50},{E4,0}; start -> C4 sounds for 100 ticks, rest for 50 ticks, then exactly one done pulse, and busy falls.
REQ-037 Same ROM with loop_en = 1 -> note_idx returns to 0 after the end marker, no done pulse, and the C4 note repeats.
REQ-038 stop asserted at tick 40 of C4 -> IDLE on the next cycle, sounding = 0, done = 0.
REQ-039 With NOTE_GAP_EN defined and GAP_TICKS = 10, a note of duration 100 -> sounding high for 90 ticks and low for 10; without the macro, high for 100.
REQ-040 clr pulsed mid-PLAY with tick asserted in the same cycle -> all outputs are 0 asynchronously; a subsequent start replays from entry 0.
REQ-041 Full 32-entry ROM with no end marker -> note_idx wraps at 31 into DONE, with no index beyond 31.
